// File: rtl/hexpad_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : hexpad_emulator_if
// Description : Key-stream and keypad-pin bundle for the hex keypad emulator.
//               The key stream carries queued key codes in from a script
//               source. col/row are the scanner-facing switch-matrix pins,
//               both active-low.
// Revision    : 1.0 - initial release
// ============================================================================
interface hexpad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [3:0] col;
  logic [3:0] row;

  // Source/scanner side: offers keys, strobes columns, senses rows
  modport master (
    output key_valid,
    output key_code,
    output col,
    input  key_ready,
    input  row
  );

  // Emulator side: accepts keys, answers column strobes on the rows
  modport slave (
    input  key_valid,
    input  key_code,
    input  col,
    output key_ready,
    output row
  );
endinterface
`default_nettype wire

// File: rtl/hexpad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : hexpad_emulator
// Description : Silicon stand-in for a 4x4 Pmod hex keypad. Key codes are
//               queued in a small FIFO. Each key is held for HOLD_TICKS clken
//               ticks and then released for GAP_TICKS ticks. While a key is
//               held, its row is pulled low whenever the scanner drives that
//               key's column low, with no clock in the col->row path.
// Revision    : 1.0 - initial release
// ============================================================================
module hexpad_emulator #(
  parameter int DEPTH      = 8,
  parameter int HOLD_TICKS = 40,
  parameter int GAP_TICKS  = 40,
  parameter int TW         = 8
) (
  input  wire                    clk,
  input  wire                    reset_n,
  input  wire                    clken,
  input  wire                    flush,
  hexpad_emulator_if.slave       kp,
  output logic                   pressed,
  output logic [3:0]             cur_key,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int              c_AW   = $clog2(DEPTH);
  localparam int              c_CW   = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);
  localparam logic [c_AW-1:0] c_PTR1 = c_AW'(1);
  localparam logic [c_CW-1:0] c_CNT1 = c_CW'(1);
  localparam logic [TW-1:0]   c_HOLD = TW'(HOLD_TICKS);
  localparam logic [TW-1:0]   c_GAP  = TW'(GAP_TICKS);
  localparam logic [TW-1:0]   c_ONE  = TW'(1);

  // Emulator sequencing states
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_PRESS = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // --------------------------------------------------------------------------
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("hexpad_emulator: DEPTH must be a power of two and at least 2");
    end
    if ((HOLD_TICKS < 1) || (GAP_TICKS < 1)) begin : g_bad_ticks
      $error("hexpad_emulator: HOLD_TICKS and GAP_TICKS must be at least 1");
    end
    if ((HOLD_TICKS >= (1 << TW)) || (GAP_TICKS >= (1 << TW))) begin : g_bad_tw
      $error("hexpad_emulator: TW too narrow for HOLD_TICKS/GAP_TICKS");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [3:0]      r_mem [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic [1:0]      r_state;
  logic [TW-1:0]   r_cnt;
  logic            r_pressed;
  logic [3:0]      r_cur_key;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [3:0]      w_head;
  logic [1:0]      w_key_row;
  logic [1:0]      w_key_col;
  logic [3:0]      w_row;

  // --------------------------------------------------------------------------
  // FIFO control
  // flush wins over everything: a push offered in the same cycle is dropped
  // and no pop is allowed to start a new key.
  // --------------------------------------------------------------------------
  assign w_empty = (r_count == '0);
  assign w_ready = (r_count != c_FULL);
  assign w_push  = kp.key_valid && w_ready && !flush;
  assign w_pop   = (r_state == c_ST_IDLE) && !w_empty && !flush;
  assign w_head  = r_mem[r_rd_ptr];

  // Key storage; contents need no reset because r_count gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= kp.key_code;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT1;
        2'b01:   r_count <= r_count - c_CNT1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Press / gap sequencer
  // The tick counter is loaded with the full duration and the phase ends on
  // the tick that sees it at one, so the phase lasts exactly that many ticks.
  // cur_key survives flush so the last key stays observable.
  // --------------------------------------------------------------------------
  // IDLE -> PRESS on pop, PRESS -> GAP and GAP -> IDLE on the final tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
      r_cur_key <= 4'h0;
    end else if (flush) begin
      r_state   <= c_ST_IDLE;
      r_cnt     <= '0;
      r_pressed <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_pop) begin
            r_cur_key <= w_head;
            r_cnt     <= c_HOLD;
            r_pressed <= 1'b1;
            r_state   <= c_ST_PRESS;
          end
        end
        c_ST_PRESS: begin
          if (clken) begin
            if (r_cnt == c_ONE) begin
              r_pressed <= 1'b0;
              r_cnt     <= c_GAP;
              r_state   <= c_ST_GAP;
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end
          end
        end
        c_ST_GAP: begin
          if (clken) begin
            r_cnt <= r_cnt - c_ONE;
            if (r_cnt == c_ONE) begin
              r_state <= c_ST_IDLE;
            end
          end
        end
        default: begin
          r_state   <= c_ST_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Switch matrix
  // Layout (row r, col c):
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: 0 F E D
  // --------------------------------------------------------------------------
  // Decode the held key's matrix position
  always_comb begin
    w_key_row = 2'd0;
    w_key_col = 2'd0;
    case (r_cur_key)
      4'h1: begin w_key_row = 2'd0; w_key_col = 2'd0; end
      4'h2: begin w_key_row = 2'd0; w_key_col = 2'd1; end
      4'h3: begin w_key_row = 2'd0; w_key_col = 2'd2; end
      4'hA: begin w_key_row = 2'd0; w_key_col = 2'd3; end
      4'h4: begin w_key_row = 2'd1; w_key_col = 2'd0; end
      4'h5: begin w_key_row = 2'd1; w_key_col = 2'd1; end
      4'h6: begin w_key_row = 2'd1; w_key_col = 2'd2; end
      4'hB: begin w_key_row = 2'd1; w_key_col = 2'd3; end
      4'h7: begin w_key_row = 2'd2; w_key_col = 2'd0; end
      4'h8: begin w_key_row = 2'd2; w_key_col = 2'd1; end
      4'h9: begin w_key_row = 2'd2; w_key_col = 2'd2; end
      4'hC: begin w_key_row = 2'd2; w_key_col = 2'd3; end
      4'h0: begin w_key_row = 2'd3; w_key_col = 2'd0; end
      4'hF: begin w_key_row = 2'd3; w_key_col = 2'd1; end
      4'hE: begin w_key_row = 2'd3; w_key_col = 2'd2; end
      4'hD: begin w_key_row = 2'd3; w_key_col = 2'd3; end
      default: begin w_key_row = 2'd0; w_key_col = 2'd0; end
    endcase
  end

  // Close the contact only while held and the key's column is strobed low;
  // other columns being low at the same time do not matter
  always_comb begin
    w_row = 4'b1111;
    if (r_pressed && !kp.col[w_key_col]) begin
      w_row[w_key_row] = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign kp.row       = w_row;
  assign kp.key_ready = w_ready;
  assign pressed      = r_pressed;
  assign cur_key      = r_cur_key;
  assign fifo_count   = r_count;
  assign busy         = (r_state != c_ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_hexpad_emulator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_hexpad_emulator
// Description : Self-checking bench for hexpad_emulator. Keys are pushed onto
//               a scoreboard as they are accepted. A monitor pops and compares
//               on every rising edge of pressed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hexpad_emulator;
    localparam int DEPTH    = 8;
    localparam int HOLD     = 4;
    localparam int GAP      = 2;
    localparam int TW       = 8;
    localparam int TICK_DIV = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       clken   = 1'b0;
    logic       flush   = 1'b0;
    logic       pressed;
    logic [3:0] cur_key;
    logic [3:0] fifo_count;
    logic       busy;

    hexpad_emulator_if kp();

    hexpad_emulator #(
        .DEPTH      (DEPTH),
        .HOLD_TICKS (HOLD),
        .GAP_TICKS  (GAP),
        .TW         (TW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clken      (clken),
        .flush      (flush),
        .kp         (kp),
        .pressed    (pressed),
        .cur_key    (cur_key),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int div = 0;
    always @(posedge clk) begin
        #2;
        div   = (div + 1) % TICK_DIV;
        clken = (div == 0);
    end

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] sb[$];
    logic       prev_pressed = 1'b0;

    logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                '{4'h4, 4'h5, 4'h6, 4'hB},
                                '{4'h7, 4'h8, 4'h9, 4'hC},
                                '{4'h0, 4'hF, 4'hE, 4'hD}};

    function automatic logic [3:0] exp_row(input logic [3:0] code, input logic [3:0] c,
                                           input logic p);
        logic [3:0] r;
        r = 4'hF;
        if (p) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (kmap[i][j] == code && c[j] == 1'b0) r[i] = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [3:0] e;
        if (reset_n === 1'b1 && pressed === 1'b1 && prev_pressed === 1'b0) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL press_order: got unexpected press of key %h, expected no press", cur_key);
            end else begin
                e = sb.pop_front();
                if (cur_key !== e) $display("FAIL press_order: cur_key=%h expected %h", cur_key, e);
                else n_pass++;
            end
        end
        prev_pressed = pressed;
    end

    task automatic push_key(input logic [3:0] code, input bit track);
        int w;
        w = 0;
        kp.key_valid = 1'b1;
        kp.key_code  = code;
        while (kp.key_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (kp.key_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL push_timeout: key_ready=%b expected 1 for key %h", kp.key_ready, code);
        end else if (track) begin
            sb.push_back(code);
        end
        @(negedge clk);
        kp.key_valid = 1'b0;
    endtask

    task automatic wait_pressed(input logic lvl, input int bound, input string what);
        int w;
        w = 0;
        while (pressed !== lvl && w < bound) begin
            @(negedge clk);
            w++;
        end
        if (pressed !== lvl) begin
            n_checks++;
            $display("FAIL %s: pressed=%b expected %b within %0d cycles", what, pressed, lvl, bound);
        end
    endtask

    task automatic wait_idle(input int bound, input string what);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < bound) begin
            @(negedge clk);
            w++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            $display("FAIL %s: busy=%b expected 0 within %0d cycles", what, busy, bound);
        end
    endtask

    task automatic test_reset();
        kp.key_valid = 1'b0;
        kp.key_code  = 4'h0;
        kp.col       = 4'hF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({kp.row, pressed, cur_key, fifo_count, kp.key_ready, busy} !== {4'hF, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0})
            $display("FAIL reset_values: row=%b pressed=%b cur_key=%h count=%0d ready=%b busy=%b expected 1111 0 0 0 1 0",
                     kp.row, pressed, cur_key, fifo_count, kp.key_ready, busy);
        else n_pass++;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pressed, busy, fifo_count} !== {1'b0, 1'b0, 4'h0})
            $display("FAIL reset_release: pressed=%b busy=%b count=%0d expected 0 0 0", pressed, busy, fifo_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_press();
        push_key(4'h5, 1'b1);
        wait_pressed(1'b1, 10, "reset_mid_start");
        push_key(4'h1, 1'b0);
        push_key(4'h2, 1'b0);
        kp.col = 4'b1101;
        #1;
        n_checks++;
        if (kp.row !== 4'b1101) $display("FAIL reset_mid_pre_row: row=%b expected 1101", kp.row);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({kp.row, pressed, fifo_count, kp.key_ready} !== {4'hF, 1'b0, 4'h0, 1'b1})
            $display("FAIL reset_mid_immediate: row=%b pressed=%b count=%0d ready=%b expected 1111 0 0 1",
                     kp.row, pressed, fifo_count, kp.key_ready);
        else n_pass++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if ({kp.row, pressed, fifo_count, busy} !== {4'hF, 1'b0, 4'h0, 1'b0})
            $display("FAIL reset_mid_hold: row=%b pressed=%b count=%0d busy=%b expected 1111 0 0 0",
                     kp.row, pressed, fifo_count, busy);
        else n_pass++;
        kp.col = 4'hF;
        sb.delete();
    endtask

    task automatic test_single();
        int         ticks;
        int         ph;
        bit         t;
        logic [3:0] one;
        one = 4'b0001;
        push_key(4'h5, 1'b1);
        n_checks++;
        if (fifo_count !== 4'd1 || pressed !== 1'b0)
            $display("FAIL single_queued: count=%0d pressed=%b expected 1 0", fifo_count, pressed);
        else n_pass++;
        wait_pressed(1'b1, 10, "single_press_start");
        ticks = 0;
        ph    = 0;
        for (int k = 0; k < 200; k++) begin
            t      = clken;
            kp.col = ~(one << ph);
            ph     = (ph + 1) % 4;
            #1;
            n_checks++;
            if (kp.row !== exp_row(4'h5, kp.col, 1'b1))
                $display("FAIL single_row_walk: col=%b row=%b expected %b", kp.col, kp.row, exp_row(4'h5, kp.col, 1'b1));
            else n_pass++;
            @(negedge clk);
            if (t) ticks++;
            if (pressed !== 1'b1) break;
        end
        n_checks++;
        if (ticks !== HOLD) $display("FAIL single_hold_ticks: held %0d ticks expected %0d", ticks, HOLD);
        else n_pass++;
        kp.col = 4'b1101;
        #1;
        n_checks++;
        if (kp.row !== 4'b1111) $display("FAIL single_released_row: row=%b expected 1111", kp.row);
        else n_pass++;
        ticks = 0;
        for (int k = 0; k < 200; k++) begin
            t = clken;
            @(negedge clk);
            if (t) ticks++;
            if (busy !== 1'b1) break;
        end
        n_checks++;
        if (ticks !== GAP || busy !== 1'b0)
            $display("FAIL single_gap_ticks: gap %0d ticks busy=%b expected %0d ticks busy=0", ticks, busy, GAP);
        else n_pass++;
        kp.col = 4'hF;
    endtask

    task automatic test_map_sweep();
        logic [3:0] one;
        logic [3:0] code;
        one = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            code = 4'(k);
            push_key(code, 1'b1);
            wait_pressed(1'b1, 10, "map_press_start");
            for (int c = 0; c < 5; c++) begin
                kp.col = (c == 4) ? 4'b0000 : ~(one << c);
                #1;
                n_checks++;
                if (kp.row !== exp_row(code, kp.col, 1'b1))
                    $display("FAIL map_key_%h: col=%b row=%b expected %b", code, kp.col, kp.row, exp_row(code, kp.col, 1'b1));
                else n_pass++;
                @(negedge clk);
            end
            kp.col = 4'hF;
            wait_idle(100, "map_idle");
        end
        push_key(4'hF, 1'b1);
        wait_pressed(1'b1, 10, "map_f_start");
        kp.col = 4'b1101;
        #1;
        n_checks++;
        if (kp.row !== 4'b0111) $display("FAIL map_f_literal: row=%b expected 0111", kp.row);
        else n_pass++;
        kp.col = 4'b0111;
        #1;
        n_checks++;
        if (kp.row !== 4'b1111) $display("FAIL map_f_wrong_col: row=%b expected 1111", kp.row);
        else n_pass++;
        kp.col = 4'hF;
        wait_idle(100, "map_f_idle");
        push_key(4'hA, 1'b1);
        wait_pressed(1'b1, 10, "map_a_start");
        kp.col = 4'b0111;
        #1;
        n_checks++;
        if (kp.row !== 4'b1110) $display("FAIL map_a_literal: row=%b expected 1110", kp.row);
        else n_pass++;
        kp.col = 4'hF;
        wait_idle(100, "map_a_idle");
    endtask

    task automatic test_backpressure();
        int         accepted;
        int         cyc;
        bit         go;
        logic [3:0] nxt;
        accepted     = 0;
        nxt          = 4'h0;
        cyc          = 0;
        kp.key_valid = 1'b1;
        kp.key_code  = nxt;
        while (nxt < 4'd10 && cyc < 400) begin
            if (cyc == 9) begin
                n_checks++;
                if (accepted !== 9 || kp.key_ready !== 1'b0)
                    $display("FAIL bp_full: accepted=%0d key_ready=%b expected 9 0", accepted, kp.key_ready);
                else n_pass++;
            end
            go = (kp.key_ready === 1'b1);
            if (go) begin
                sb.push_back(nxt);
                accepted++;
            end
            @(negedge clk);
            cyc++;
            if (go) begin
                nxt         = nxt + 4'd1;
                kp.key_code = nxt;
            end
        end
        kp.key_valid = 1'b0;
        n_checks++;
        if (accepted !== 10 || cyc <= 10)
            $display("FAIL bp_tenth: accepted=%0d after %0d cycles expected 10 after stall", accepted, cyc);
        else n_pass++;
        wait_idle(1000, "bp_idle");
        n_checks++;
        if (sb.size() !== 0) $display("FAIL bp_replay: %0d keys not replayed expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        push_key(4'h7, 1'b1);
        wait_pressed(1'b1, 10, "flush_press_start");
        push_key(4'h1, 1'b0);
        push_key(4'h2, 1'b0);
        push_key(4'h3, 1'b0);
        n_checks++;
        if (fifo_count !== 4'd3 || pressed !== 1'b1)
            $display("FAIL flush_setup: count=%0d pressed=%b expected 3 1", fifo_count, pressed);
        else n_pass++;
        flush        = 1'b1;
        kp.key_valid = 1'b1;
        kp.key_code  = 4'hE;
        @(negedge clk);
        flush        = 1'b0;
        kp.key_valid = 1'b0;
        kp.col       = 4'b1110;
        #1;
        n_checks++;
        if ({pressed, kp.row, fifo_count, busy, cur_key} !== {1'b0, 4'hF, 4'h0, 1'b0, 4'h7})
            $display("FAIL flush_result: pressed=%b row=%b count=%0d busy=%b cur_key=%h expected 0 1111 0 0 7",
                     pressed, kp.row, fifo_count, busy, cur_key);
        else n_pass++;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({pressed, fifo_count, busy} !== {1'b0, 4'h0, 1'b0})
            $display("FAIL flush_push_dropped: pressed=%b count=%0d busy=%b expected 0 0 0", pressed, fifo_count, busy);
        else n_pass++;
        kp.col = 4'hF;
    endtask

    task automatic test_push_pop();
        int w;
        push_key(4'h1, 1'b1);
        wait_pressed(1'b1, 10, "pp_press_start");
        push_key(4'h2, 1'b1);
        push_key(4'h3, 1'b1);
        w = 0;
        while (dut.r_state != 2'd0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (fifo_count !== 4'd2 || dut.r_state !== 2'd0)
            $display("FAIL pp_setup: count=%0d state=%0d expected 2 0", fifo_count, dut.r_state);
        else n_pass++;
        kp.key_valid = 1'b1;
        kp.key_code  = 4'h4;
        sb.push_back(4'h4);
        @(negedge clk);
        kp.key_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 4'd2 || pressed !== 1'b1)
            $display("FAIL pp_count: count=%0d pressed=%b expected 2 1", fifo_count, pressed);
        else n_pass++;
        wait_idle(400, "pp_idle");
        n_checks++;
        if (sb.size() !== 0) $display("FAIL pp_replay: %0d keys not replayed expected 0", sb.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_mid_press();
        test_single();
        test_map_sweep();
        test_backpressure();
        test_flush();
        test_push_pop();
        repeat (5) @(negedge clk);
        $display("RESULT: %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation still running at 200us, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hexpad_emulator.md
# hexpad_emulator

Behavioural-in-silicon model of the 4x4 Pmod hex keypad: the responder at the far end of the keypad scanner's column-drive/row-sense interface. It accepts a queue of 4-bit key codes, presses each key for a programmed time, then releases it for a programmed gap. While a key is pressed, it drives the matching row low whenever the scanner strobes that key's column. It sits between a test/script source and the keypad scanner's `row`/`col` pins, allowing hands-free entry and self-test of the SAP-1 front panel.

## Interface
Parameters:
- `DEPTH`, 8: key FIFO depth; power of 2, ≥2.
- `HOLD_TICKS`, 40: press duration in `clken` ticks; ≥1.
- `GAP_TICKS`, 40: release duration after each key in `clken` ticks; ≥1.
- `TW`, 8: tick counter width; must hold max(HOLD_TICKS, GAP_TICKS).

Ports:
- `clk`  in  1  system clock (100 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `clken`  in  1  1 kHz single-cycle timing tick.
- `flush`  in  1  synchronous; empty FIFO, release key, go IDLE.
- `key_valid`  in  1  key code offered.
- `key_code`  in  4  hex key 0x0–0xF.
- `key_ready`  out  1  FIFO not full; push occurs when `key_valid & key_ready`.
- `col`  in  4  column strobes from scanner, active-low.
- `row`  out  4  row returns to scanner, active-low (1111 = no contact).
- `pressed`  out  1  a key is currently held.
- `cur_key`  out  4  code of held/last-pressed key.
- `fifo_count`  out  $clog2(DEPTH)+1  queued entries.
- `busy`  out  1  state≠IDLE or FIFO non-empty.

## Operation
- Key map, fixed (row r, col c):
  - Row 0: 1, 2, 3, A in cols 0–3.
  - Row 1: 4, 5, 6, B.
  - Row 2: 7, 8, 9, C.
  - Row 3: 0, F, E, D.
- Row drive, combinational from `col`: `row[r]=0` iff `pressed`, r = row(`cur_key`), and `col[c]==0` for c = col(`cur_key`); otherwise `row[r]=1`.
  - Multiple columns low: the row is still driven low if the key's column is among them.
- FIFO:
  - `key_ready = (fifo_count != DEPTH)`.
  - Push and pop in the same cycle is legal; count is unchanged.
  - Pop when empty never happens.
- FSM (IDLE, PRESS, GAP):
  - IDLE: if FIFO non-empty, pop head into `cur_key`, load `cnt=HOLD_TICKS`, set `pressed=1`, go to PRESS. No bypass: an entry pushed into an empty FIFO is popped on the following cycle.
  - PRESS: on `clken`, `cnt--`. On `clken` with `cnt==1`: `pressed=0`, `cnt=GAP_TICKS`, go to GAP.
  - GAP: on `clken`, `cnt--`. On `clken` with `cnt==1`, go to IDLE.
- `flush` has priority over all FSM and FIFO activity:
  - Next edge: FIFO count 0, `pressed=0`, state IDLE.
  - A push in the same cycle is discarded.
  - `cur_key` holds its value.
- `reset_n` low at any time (including mid-press): immediate release, with state as listed under reset values.

## Timing
- Reset values:
  - `row`=1111, `pressed`=0, `cur_key`=0, `fifo_count`=0, `key_ready`=1, `busy`=0.
  - State IDLE, `cnt`=0.
- Push → `fifo_count` updates next edge. Pop to `pressed`=1 takes 1 cycle from IDLE.
- Press length: from the rising of `pressed` through the HOLD_TICKS-th `clken` after entry. That is HOLD_TICKS ticks ±1 tick of phase.
- Gap length: GAP_TICKS `clken` ticks after release. The next key can rise 1 cycle after GAP exits.
- `row` responds to `col` in the same cycle (zero-cycle path), modelling switch contacts.
- `busy` is registered-state derived; it falls on the cycle IDLE is entered with an empty FIFO.

## Test plan
- Reset: assert `reset_n`=0 mid-PRESS of key 5 → `row`=1111, `pressed`=0, `fifo_count`=0, `key_ready`=1 immediately; hold after release.
- Single key: HOLD=4, GAP=2, push 0x5, walk `col` 1110/1101/1011/0111 each cycle.
  - `row`=1101 only while `col`=1101.
  - `pressed` high for exactly 4 ticks, then low.
  - `busy` falls 2 ticks later.
- Map sweep: push all 16 codes 0x0–0xF and scan each column.
  - The asserted (row, col) pair matches the key map for each code, e.g. 0xF → row 3 with col 1, `row`=0111.
  - 0xA → row 0 with col 3.
- Backpressure: DEPTH=8, hold `key_valid` with codes 0..9 on consecutive cycles.
  - 9 accepted (one popped at cycle 1).
  - `key_ready`=0 after the 9th; the 10th is stalled until the first press completes, then accepted.
  - Keys are replayed in order 0..9.
- Flush: `flush` during PRESS of key 7 with 3 queued → next cycle `pressed`=0, `row`=1111, `fifo_count`=0, `busy`=0, `cur_key`=7; a simultaneous push is dropped.
- Simultaneous push/pop: FIFO holding 2, push as IDLE pops → `fifo_count` stays 2.
